ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  PS/2 host-to-device transmitter: sends one command byte (e.g. 8'hED set-LEDs, 8'hFF reset) to the keyboard.
//  It is the opposite direction of the keyboard receive/decode path and sits beside it on the shared PS2_clk/PS2_data pins.
//  It drives the open-drain lines through active-high pull-low enables, follows the device-generated clock, and reports the device ack.
// PARAMETERS
//  INHIBIT_CYCLES  12000    clk cycles the host holds PS2 clock low before the request (120 us at 100 MHz)
//  TIMEOUT_CYCLES  1500000  max clk cycles between device clock falling edges before abort (15 ms)
//  FILTER_LEN      8        consecutive equal synchronised samples needed to accept a PS2 clock level change
// PORTS
//  clk          in   1  system clock, 100 MHz
//  rst_n        in   1  asynchronous reset, active-low
//  tx_valid     in   1  command byte available
//  tx_data      in   8  command byte
//  tx_ready     out  1  block idle, can accept a byte
//  ps2_clk_i    in   1  PS2_clk pin level (asynchronous)
//  ps2_data_i   in   1  PS2_data pin level (asynchronous)
//  ps2_clk_oe   out  1  1 = pull PS2_clk low, 0 = release
//  ps2_data_oe  out  1  1 = pull PS2_data low, 0 = release
//  busy         out  1  transfer in progress; the receive path ignores line activity while this is high
//  done         out  1  one-cycle pulse at end of transfer
//  ack_ok       out  1  valid with done: 1 = device acked (data low at ack bit)
//  err          out  1  one-cycle pulse: timeout or missing ack
// BEHAVIOUR
//  - Reset (async, rst_n=0): both *_oe=0 immediately, state IDLE, tx_ready=1, busy=done=ack_ok=err=0, counters cleared.
//  - Input path: ps2_clk_i and ps2_data_i each pass through a 2-FF synchroniser.
//    The clock level is then filtered over FILTER_LEN samples; fall = filtered level 1->0.
//  - Handshake: a byte is accepted when tx_valid & tx_ready. tx_data is latched and parity = ~^tx_data (odd parity).
//    tx_ready = (state==IDLE). tx_valid is ignored while busy.
//  - States:
//    IDLE:    both oe=0. Acceptance -> INHIBIT next cycle.
//    INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_CYCLES. Then data_oe=1 (start bit 0) for 1 cycle with clk_oe still 1 -> REQ.
//    REQ:     clk_oe=0, data_oe=1. Wait for fall -> SHIFT, bitcnt=0.
//    SHIFT:   on each fall, drive the next bit: data_oe=~bit.
//             Order: tx_data[0..7] LSB first, then parity, then stop (data_oe=0). bitcnt 0..9.
//             After the stop bit is driven -> ACK.
//    ACK:     on the next fall, sample filtered data: 0 -> ack_ok=1, 1 -> ack_ok=0. -> WAITIDLE.
//    WAITIDLE: wait until synced clk=1 and data=1 -> IDLE.
//             Pulse done with ack_ok; pulse err if ack_ok=0.
//  - Timeout: a counter reset on every fall runs in REQ/SHIFT/ACK/WAITIDLE.
//    Reaching TIMEOUT_CYCLES -> both oe=0, err pulse, done pulse with ack_ok=0, -> IDLE.
//  - busy=1 in all states except IDLE. done and err never assert in the same cycle as acceptance.
//  - ack_ok holds its value until the next done.
//  - Reset mid-transfer releases the lines within the same cycle (asynchronous). The device times out on its own.
//  - A device clock edge during INHIBIT is ignored (the host owns the bus).
// CONFIGURATION
//  PS2_TX_RETRY_EN defined:
//    on timeout or missing ack, the latched byte is resent from INHIBIT up to 2 more times.
//    err/done pulse only after the final failing attempt. busy stays high throughout.
//  Undefined: a single attempt; err/done are reported on the first failure.
// TESTING
//  1. Device model acks; send 8'hED -> data bits 1,0,1,1,0,1,1,1 on successive falls.
//     Then parity=1, stop=1, done=1, ack_ok=1, err=0.
//  2. Send 8'h07 -> parity bit 0. Send 8'h00 -> parity bit 1. Both acked; tx_ready returns to 1 after each done.
//  3. Check INHIBIT -> clk_oe high for exactly 12000 cycles, then data_oe=1 before clk_oe drops to 0.
//  4. Device leaves data high at the ack bit -> done=1, ack_ok=0, err=1.
//     With PS2_TX_RETRY_EN: 3 full frames, then a single err.
//  5. Device stops clocking after bit 3 -> err exactly 1500000 cycles after the last fall, both oe=0.
//  6. rst_n low mid-SHIFT -> ps2_clk_oe=ps2_data_oe=0 at once. After release, tx_ready=1 and a new 8'hFF is sent correctly.

Source files
------------

// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
//
// PS/2 host-to-device transmitter. Sends one command byte (e.g. 8'hED set-LEDs,
// 8'hFF reset) to the keyboard over the shared open-drain PS2_clk/PS2_data
// lines. The lines are driven through active-high pull-low enables. The device
// generates the bit clock, and the block reports whether the device acked.
//
// Frame on the wire: start(0), data[0..7] LSB first, odd parity, stop(1).
// The device acks by pulling data low on the eleventh clock.
//
// Parameters
//   INHIBIT_CYCLES  clk cycles the host holds PS2_clk low before the request
//   TIMEOUT_CYCLES  max clk cycles between device clock falls before abort
//   FILTER_LEN      consecutive differing samples needed to accept a new
//                   PS2_clk level
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   tx_valid/ready  byte handshake; tx_data is the command byte
//   ps2_clk_i       PS2_clk pin level (asynchronous)
//   ps2_data_i      PS2_data pin level (asynchronous)
//   ps2_clk_oe      1 = pull PS2_clk low
//   ps2_data_oe     1 = pull PS2_data low
//   busy            transfer in progress (receive path ignores the lines)
//   done            one-cycle pulse at end of transfer
//   ack_ok          valid with done, held until the next done
//   err             one-cycle pulse on timeout or missing ack
//
// Configuration macro
//   PS2_TX_RETRY_EN  when defined, a failed frame is resent from INHIBIT up to
//                    2 more times; done/err report only the final attempt.
// -----------------------------------------------------------------------------
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 12000,
   parameter int unsigned TIMEOUT_CYCLES = 1500000,
   parameter int unsigned FILTER_LEN     = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_ok,
   output logic       err
);

   localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                     INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W = $clog2(CNT_MAX + 1);
   localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_REQ,
      ST_SHIFT,
      ST_ACK,
      ST_WAITIDLE
   } state_e;

   // ---------------------------------------------------------------------------
   // Input synchronisers and PS2_clk glitch filter
   // ---------------------------------------------------------------------------
   logic [1:0]       clk_sync_q;
   logic [1:0]       data_sync_q;
   logic             clk_s;
   logic             data_s;
   logic             clk_filt_q;
   logic [FLT_W-1:0] flt_cnt_q;
   logic             flt_flip;
   logic             fall;

   assign clk_s  = clk_sync_q[1];
   assign data_s = data_sync_q[1];

   // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
   assign flt_flip = (clk_s != clk_filt_q) &&
                     (flt_cnt_q == FLT_W'(FILTER_LEN - 1));
   assign fall     = flt_flip && clk_filt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // Idle bus lines float high, so the pipeline starts at 1.
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         clk_filt_q  <= 1'b1;
         flt_cnt_q   <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples the values from before this edge, regardless of order.
         clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
         data_sync_q <= {data_sync_q[0], ps2_data_i};
         if (clk_s == clk_filt_q) begin
            flt_cnt_q <= '0;
         end else if (flt_flip) begin
            clk_filt_q <= clk_s;
            flt_cnt_q  <= '0;
         end else begin
            flt_cnt_q <= flt_cnt_q + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Transfer FSM
   // ---------------------------------------------------------------------------
   state_e           state_q;
   logic [9:0]       frame_q;    // {stop, parity, data}, bit 0 sent first
   logic [9:0]       frame_d;
   logic [3:0]       bit_cnt_q;
   logic [3:0]       bit_cnt_d;
   logic [CNT_W-1:0] cnt_q;      // inhibit length, then inter-fall timeout
   logic [CNT_W-1:0] cnt_d;
   logic             clk_oe_q;
   logic             data_oe_q;
   logic             ack_rx_q;   // ack level seen on the current attempt
   logic             ack_ok_q;
   logic             done_q;
   logic             err_q;
   logic             active;
   logic             timeout;
   logic             finish;
   logic             failed;
   logic             retry;

   assign frame_d   = {1'b1, ~^tx_data, tx_data};
   assign bit_cnt_d = bit_cnt_q + 1'b1;
   assign cnt_d     = fall ? '0 : cnt_q + 1'b1;

   assign active  = (state_q == ST_REQ) || (state_q == ST_SHIFT) ||
                    (state_q == ST_ACK) || (state_q == ST_WAITIDLE);
   assign timeout = active && !fall &&
                    (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign finish  = timeout || ((state_q == ST_WAITIDLE) && clk_s && data_s);
   assign failed  = timeout || !ack_rx_q;

`ifdef PS2_TX_RETRY_EN
   logic [1:0] try_q;            // retries already spent on this byte

   assign retry = finish && failed && (try_q != 2'd2);
`else
   assign retry = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         frame_q   <= '0;
         bit_cnt_q <= '0;
         cnt_q     <= '0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         ack_rx_q  <= 1'b0;
         ack_ok_q  <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
         try_q     <= '0;
`endif
      end else begin
         // NOTE: pulse outputs default low every cycle and are raised only on
         // the edge that ends a transfer, so they never stick high.
         done_q <= 1'b0;
         err_q  <= 1'b0;

         if (retry) begin
            // Resend the latched frame; busy stays high across attempts.
            state_q   <= ST_INHIBIT;
            clk_oe_q  <= 1'b1;
            data_oe_q <= 1'b0;
            cnt_q     <= '0;
`ifdef PS2_TX_RETRY_EN
            try_q     <= try_q + 1'b1;
`endif
         end else if (finish) begin
            state_q   <= ST_IDLE;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= failed;
            ack_ok_q  <= !failed;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (tx_valid && tx_ready) begin
                     frame_q   <= frame_d;
                     state_q   <= ST_INHIBIT;
                     clk_oe_q  <= 1'b1;
                     data_oe_q <= 1'b0;
                     cnt_q     <= '0;
`ifdef PS2_TX_RETRY_EN
                     try_q     <= '0;
`endif
                  end
               end

               // Clock held low INHIBIT_CYCLES, then one extra cycle with the
               // start bit already on data before the clock is released.
               ST_INHIBIT: begin
                  if (cnt_q == CNT_W'(INHIBIT_CYCLES)) begin
                     clk_oe_q <= 1'b0;
                     cnt_q    <= '0;
                     state_q  <= ST_REQ;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                     if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                        data_oe_q <= 1'b1;
                     end
                  end
               end

               // The first device fall asks for data bit 0.
               ST_REQ: begin
                  cnt_q <= cnt_d;
                  if (fall) begin
                     data_oe_q <= ~frame_q[0];
                     bit_cnt_q <= '0;
                     state_q   <= ST_SHIFT;
                  end
               end

               ST_SHIFT: begin
                  cnt_q <= cnt_d;
                  if (fall) begin
                     data_oe_q <= ~frame_q[bit_cnt_d];
                     bit_cnt_q <= bit_cnt_d;
                     if (bit_cnt_d == 4'd9) begin
                        state_q <= ST_ACK;
                     end
                  end
               end

               // Device pulls data low for ack; host has released data.
               ST_ACK: begin
                  cnt_q <= cnt_d;
                  if (fall) begin
                     ack_rx_q <= ~data_s;
                     state_q  <= ST_WAITIDLE;
                  end
               end

               ST_WAITIDLE: begin
                  cnt_q <= cnt_d;
               end

               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // tx_ready is held low during the done cycle so acceptance never coincides
   // with a done/err pulse.
   assign tx_ready    = (state_q == ST_IDLE) && !done_q;
   assign busy        = (state_q != ST_IDLE);
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign done        = done_q;
   assign err         = err_q;
   assign ack_ok      = ack_ok_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// -----------------------------------------------------------------------------
// tb_ps2_host_tx
//
// Bench for ps2_host_tx with a behavioural PS/2 keyboard on the open-drain
// lines. Expected results are queued when each byte is issued, and a monitor
// pops and compares them whenever the DUT pulses done. The keyboard model
// records every complete frame it clocks in (data, parity, stop) for the
// monitor to compare. The DUT is built with short inhibit/timeout values so the
// run stays short.
// -----------------------------------------------------------------------------
module tb_ps2_host_tx;

   localparam int INH      = 120;
   localparam int TO       = 2000;
   localparam int FLT      = 8;
   localparam int HALF     = 25;   // device clock half period in clk cycles
   localparam int FALL_LAT = 10;   // 2 sync stages + FLT filter samples
`ifdef PS2_TX_RETRY_EN
   localparam int NACK_FRAMES = 3;
`else
   localparam int NACK_FRAMES = 1;
`endif

   logic       clk;
   logic       rst_n;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       ps2_clk_i;
   logic       ps2_data_i;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;
   logic       busy;
   logic       done;
   logic       ack_ok;
   logic       err;

   // Device side of the open-drain bus.
   logic       dev_clk_low;
   logic       dev_data_low;
   bit         dev_ack;
   int         dev_stop;
   bit         dev_busy;
   int         dev_fall_cnt;
   int         last_fall_cyc;

   int         cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       ack;
      logic       err;
      int         frames;
      bit         chk_time;
   } exp_t;

   exp_t       exp_q[$];
   logic [9:0] frame_q[$];

   assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TO),
      .FILTER_LEN     (FLT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .ps2_clk_i   (ps2_clk_i),
      .ps2_data_i  (ps2_data_i),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .busy        (busy),
      .done        (done),
      .ack_ok      (ack_ok),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------------------------------------------------------------------
   // Keyboard model: clocks a host request, samples data on rising edges and
   // optionally pulls data low for the ack bit. Stops early after dev_stop falls.
   // ---------------------------------------------------------------------------
   task automatic serve();
      logic [9:0] bits;
      bit         ack;
      int         stop;
      ack          = dev_ack;
      stop         = dev_stop;
      bits         = '0;
      dev_busy     = 1'b1;
      dev_fall_cnt = 0;
      tick(HALF);
      for (int k = 1; k <= 11; k++) begin
         if (k > stop) break;
         dev_clk_low   = 1'b1;
         dev_fall_cnt++;
         last_fall_cyc = cyc;
         tick(HALF);
         dev_clk_low = 1'b0;
         if (k <= 10) bits[k-1] = ps2_data_i;
         if (k == 10 && ack) dev_data_low = 1'b1;
         if (k == 11) dev_data_low = 1'b0;
         else tick(HALF);
      end
      if (stop >= 11) frame_q.push_back(bits);
      dev_busy = 1'b0;
   endtask

   initial begin : device
      bit prev_oe;
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      dev_busy     = 1'b0;
      dev_fall_cnt = 0;
      prev_oe      = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         // Request = host releases the clock while holding data low.
         if (prev_oe && !ps2_clk_oe && ps2_data_oe) serve();
         prev_oe = ps2_clk_oe;
      end
   end

   // ---------------------------------------------------------------------------
   // Inhibit shape: clock-low-only run of INH cycles, one cycle with both
   // pulled, then the clock released with the start bit still driven.
   // ---------------------------------------------------------------------------
   initial begin : inhibit_chk
      int n;
      bit started;
      n       = 0;
      started = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (ps2_clk_oe && !ps2_data_oe) begin
            n++;
         end else if (ps2_clk_oe && ps2_data_oe) begin
            if (n > 0) begin
               check("inhibit_len", n, INH);
               n       = 0;
               started = 1'b1;
            end
         end else begin
            if (started) begin
               check("req_start_bit", ps2_data_oe, 1'b1);
               started = 1'b0;
            end
            n = 0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Scoreboard monitor
   // ---------------------------------------------------------------------------
   initial begin : monitor
      exp_t       e;
      logic [9:0] f;
      bit         want_ready;
      want_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (want_ready) begin
            check("ready_after_done", tx_ready, 1'b1);
            want_ready = 1'b0;
         end
         if (err && !done) check("err_with_done", done, 1'b1);
         if (done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", done, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("ack_ok", ack_ok, e.ack);
               check("err", err, e.err);
               check("lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
               check("ready_low_at_done", tx_ready, 1'b0);
               check("frame_count", frame_q.size(), e.frames);
               while (frame_q.size() > 0) begin
                  f = frame_q.pop_front();
                  check("frame", f, {1'b1, e.par, e.data});
               end
               if (e.chk_time) check("timeout_latency", cyc - last_fall_cyc, TO + FALL_LAT);
               want_ready = 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   task automatic issue(input logic [7:0] d);
      int n;
      @(posedge clk);
      #1;
      tx_valid = 1'b1;
      tx_data  = d;
      n = 0;
      while (!tx_ready && n < 1000) begin
         tick(1);
         n++;
      end
      if (!tx_ready) check("ready_wait", tx_ready, 1'b1);
      tick(1);
      check("busy_after_accept", busy, 1'b1);
      // A different byte offered while busy must not disturb the frame.
      tx_data = 8'h55;
      tick(20);
      tx_valid = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic p, input bit ack,
                       input int stop, input int frames, input logic ack_exp,
                       input logic err_exp, input bit chk_time);
      exp_t e;
      int   n;
      dev_ack    = ack;
      dev_stop   = stop;
      e.data     = d;
      e.par      = p;
      e.ack      = ack_exp;
      e.err      = err_exp;
      e.frames   = frames;
      e.chk_time = chk_time;
      exp_q.push_back(e);
      issue(d);
      n = 0;
      while (exp_q.size() != 0 && n < 20000) begin
         tick(1);
         n++;
      end
      if (exp_q.size() != 0) begin
         check("transfer_completes", exp_q.size(), 0);
         exp_q.delete();
         frame_q.delete();
      end
      tick(3);
   endtask

   initial begin : main
      int n;
      rst_n    = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      dev_ack  = 1'b1;
      dev_stop = 11;
      #12;
      check("rst_clk_oe", ps2_clk_oe, 1'b0);
      check("rst_data_oe", ps2_data_oe, 1'b0);
      check("rst_tx_ready", tx_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_ack_ok", ack_ok, 1'b0);
      check("rst_err", err, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      tick(5);

      // Acked transfers; parity hand-computed (odd parity).
      send(8'hED, 1'b1, 1'b1, 11, 1, 1'b1, 1'b0, 1'b0);
      send(8'h07, 1'b0, 1'b1, 11, 1, 1'b1, 1'b0, 1'b0);
      send(8'h00, 1'b1, 1'b1, 11, 1, 1'b1, 1'b0, 1'b0);
      // Device leaves data high at the ack bit.
      send(8'hF4, 1'b0, 1'b0, 11, NACK_FRAMES, 1'b0, 1'b1, 1'b0);
      // Device stops clocking after bit 3 has been driven (4 falls).
      send(8'hED, 1'b1, 1'b1, 4, 0, 1'b0, 1'b1, 1'b1);

      // Reset in the middle of SHIFT.
      dev_ack      = 1'b1;
      dev_stop     = 5;
      dev_fall_cnt = 0;
      issue(8'hA5);
      n = 0;
      while (dev_fall_cnt < 3 && n < 2000) begin
         tick(1);
         n++;
      end
      if (dev_fall_cnt < 3) check("reach_shift", dev_fall_cnt, 3);
      tick(5);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_clk_oe", ps2_clk_oe, 1'b0);
      check("midrst_data_oe", ps2_data_oe, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_tx_ready", tx_ready, 1'b1);
      n = 0;
      while (dev_busy && n < 2000) begin
         tick(1);
         n++;
      end
      if (dev_busy) check("device_idle", dev_busy, 1'b0);
      frame_q.delete();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      tick(5);
      send(8'hFF, 1'b1, 1'b1, 11, 1, 1'b1, 1'b0, 1'b0);

      tick(20);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #5ms;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
      $fatal(1);
   end

endmodule
